rom_burst_arbiter: RTL and testbench
====================================

Name: rom_burst_arbiter

Overview:
- Shares one synchronous sprite/graphics ROM between N_REQ requesters, e.g. duck sprite, obstacle, ground and score renderers.
- The ROM has 1-cycle read latency and one read per clock.
- Each requester asks for a burst, given as a base address plus a length. The arbiter grants requesters round-robin and issues one ROM address per clock for the granted burst.
- Read data comes back tagged with requester, address and burst offset, so sprite line buffers can fill directly from the ROM.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, ROM data width.
- DEPTH, 256, ROM depth in words.
- LENW, 6, width of the burst length field (max burst 2^LENW-1).
- ADDRW, $clog2(DEPTH), local, address width.
- IDW, $clog2(N_REQ), local, requester index width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  N_REQ  burst request per requester.
- req_base  in  N_REQ*ADDRW  packed base address; slice i belongs to requester i.
- req_len  in  N_REQ*LENW  packed burst length.
- req_ready  out  N_REQ  one-cycle accept pulse, one-hot or zero.
- rom_addr  out  ADDRW  address to the ROM.
- rom_data  in  WIDTH  ROM read data, valid 1 cycle after rom_addr.
- rsp_valid  out  N_REQ  one-hot: rsp_data is for requester i.
- rsp_data  out  WIDTH  returned word (rom_data passed through).
- rsp_addr  out  ADDRW  address that produced rsp_data.
- rsp_idx  out  LENW  offset of this word within its burst.
- rsp_last  out  1  marks the final word of a burst.
- busy  out  1  high while in BURST.

Behaviour:
- Reset (rst_n low at a posedge):
  - State returns to IDLE; round-robin pointer goes to 0.
  - All counters clear.
  - req_ready, rsp_valid, rsp_last and busy are 0 from the next cycle.
  - rom_addr, rsp_addr, rsp_idx and rsp_data are 0.
  - A reset mid-burst abandons the burst. The in-flight read is dropped with no rsp_valid and no rsp_last.
- FSM states: IDLE and BURST.
- IDLE:
  - If any req_valid is high, pick the winner w. Search starts at the pointer and goes upward modulo N_REQ; the first valid requester wins.
  - Assert req_ready[w] combinationally in that cycle.
  - On the same posedge, latch base = req_base[w], len = req_len[w] and tag = w, and set the pointer to (w+1) mod N_REQ.
  - If len != 0, go to BURST. If len == 0, stay in IDLE: the burst is accepted, no reads are issued and no response is produced.
- Requester contract:
  - Hold req_valid, base and len stable until req_ready is seen.
  - Drop req_valid, or present a new burst, in the cycle after req_ready.
  - Non-winners keep waiting; round-robin guarantees each is served within N_REQ grants.
- BURST:
  - The cycle counter i runs 0..len-1, one address per clock.
  - rom_addr = (base + i) mod DEPTH, so bursts wrap past DEPTH-1 to 0.
  - After issuing i = len-1, return to IDLE on the next posedge.
  - No new grant is made while in BURST.
  - busy = 1 exactly in BURST.
- rom_addr in IDLE holds its last value. Issued reads are qualified only by an internal issue flag, never by rom_addr itself.
- Response pipeline:
  - One register stage mirrors the ROM latency, holding issue-valid, tag, address, idx and last.
  - In the cycle after address (base+i) is issued:
    - rsp_valid[tag] = 1;
    - rsp_data = rom_data;
    - rsp_addr = base+i;
    - rsp_idx = i;
    - rsp_last = (i == len-1).
- Latency:
  - Grant at cycle T gives the first address at T+1 and the first data at T+2.
  - The last data arrives at T+len+1.
  - The next grant can happen at T+len+1, overlapping the last response. Its first data arrives at T+len+3, so there is a 1-cycle bubble between bursts.
- Simultaneous requests resolve by the rotating pointer only; there is no fixed priority.
- A requester that drops req_valid before being granted is simply skipped.

Decomposition:
- Shared package (graphics params package) holds:
  - ROM geometry constants (DEPTH, WIDTH);
  - LENW;
  - requester index constants (REQ_DUCK, REQ_OBST, REQ_GROUND, REQ_SCORE);
  - the FSM state encoding.
- One sub-module: rr_arbiter (N_REQ-wide, combinational round-robin pick from a pointer, plus one-hot grant and index outputs).
- The ROM is instantiated beside this block, not inside it.

Test Plan:
- Single burst: after reset, req0 base=0x10 len=4 with ROM word = address.
  - rom_addr shows 10,11,12,13 on T+1..T+4.
  - rsp_valid=0001 on T+2..T+5 with data 10..13 and idx 0..3.
  - rsp_last only on data 13; busy high T+1..T+4.
- Round-robin: req0..req3 all valid with len=2 and bases 0x00/0x40/0x80/0xC0.
  - Grants come in order 0,1,2,3, each at 3-cycle spacing.
  - req_ready is one-hot and each requester receives exactly 2 words.
  - When req0 re-requests at once, it is granted only after req3.
- Wrap-around: base=0xFE len=4 -> rom_addr FE,FF,00,01; rsp_addr matches and data returns in order.
- Zero length: req2 len=0.
  - req_ready[2] pulses once.
  - No rom reads, no rsp_valid, busy stays 0.
  - An immediately following req1 len=1 is granted the next cycle.
- Reset mid-burst: rst_n low during cycle T+3 of a len=8 burst.
  - From the next cycle: rsp_valid=0, busy=0, req_ready=0.
  - The pointer resets, so a fresh simultaneous request from req0 and req1 grants req0.
- Max length: len=63 from base 0x00.
  - 63 consecutive rsp_valid with idx 0..62 and no gaps.
  - rsp_last on idx 62.

Source files
------------

// File: rtl/rom_burst_arbiter_pkg.sv
// Shared graphics parameters: ROM geometry, burst length width,
// requester slot numbering and the burst arbiter state encoding.
package rom_burst_arbiter_pkg;

  // Sprite/graphics ROM geometry
  localparam int ROM_DEPTH  = 256;
  localparam int ROM_WIDTH  = 8;

  // Burst length field width (longest burst is 2**BURST_LENW - 1 words)
  localparam int BURST_LENW = 6;

  // Requester slot assignment used by the renderers
  localparam int REQ_DUCK   = 0;
  localparam int REQ_OBST   = 1;
  localparam int REQ_GROUND = 2;
  localparam int REQ_SCORE  = 3;

  // Arbiter states: waiting for a request, or streaming a granted burst
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/rom_burst_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first active request found when
// searching upward from the pointer (wrapping) wins.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDW-1:0]   o_idx,
  output logic             o_any
);

  // Distance of each requester from the pointer, measured upward mod N_REQ
  int w_dist [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dist
    assign w_dist[gi] = (gi >= int'(i_ptr)) ? (gi - int'(i_ptr))
                                            : (gi + N_REQ - int'(i_ptr));
  end

  // Choose the active requester nearest the pointer and form its one-hot grant
  always_comb begin
    int best_d;
    best_d  = N_REQ;
    o_idx   = '0;
    o_grant = '0;
    o_any   = |i_req;
    for (int j = 0; j < N_REQ; j++) begin
      if (i_req[j] && (w_dist[j] < best_d)) begin
        best_d = w_dist[j];
        o_idx  = IDW'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      o_grant[j] = o_any && (o_idx == IDW'(j));
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin burst arbiter in front of a shared 1-cycle-latency ROM.
// A granted burst issues one address per clock; returning words are
// tagged with requester, address, burst offset and a last marker.
module rom_burst_arbiter
  import rom_burst_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = ROM_WIDTH,
  parameter  int DEPTH = ROM_DEPTH,
  parameter  int LENW  = BURST_LENW,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*ADDRW-1:0] req_base,
  input  logic [N_REQ*LENW-1:0] req_len,
  output logic [N_REQ-1:0]      req_ready,
  output logic [ADDRW-1:0]      rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ADDRW-1:0]      rsp_addr,
  output logic [LENW-1:0]       rsp_idx,
  output logic                  rsp_last,
  output logic                  busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_tag;
  logic [LENW-1:0]  r_len;
  logic [LENW-1:0]  r_cnt;
  logic [ADDRW-1:0] r_rom_addr;

  // Response stage registers (aligned with the ROM's read latency)
  logic             r_p_vld;
  logic [IDW-1:0]   r_p_tag;
  logic [ADDRW-1:0] r_p_addr;
  logic [LENW-1:0]  r_p_idx;
  logic             r_p_last;

  logic [N_REQ-1:0] w_grant;
  logic [IDW-1:0]   w_win;
  logic             w_any;
  logic             w_accept;
  logic             w_issue;
  logic             w_last_issue;
  logic [IDW-1:0]   w_ptr_next;
  logic [ADDRW-1:0] w_addr_inc;
  logic [ADDRW-1:0] w_base_sel;
  logic [LENW-1:0]  w_len_sel;
  logic [ADDRW-1:0] w_base_arr [N_REQ];
  logic [LENW-1:0]  w_len_arr  [N_REQ];

  // Unpack the per-requester base/length slices
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_base_arr[gi] = req_base[gi*ADDRW +: ADDRW];
    assign w_len_arr[gi]  = req_len[gi*LENW +: LENW];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  assign w_base_sel = w_base_arr[w_win];
  assign w_len_sel  = w_len_arr[w_win];
  assign w_ptr_next = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + IDW'(1);
  assign w_addr_inc = (r_rom_addr == ADDRW'(DEPTH - 1)) ? '0 : r_rom_addr + ADDRW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, grant pulse, issue qualifier and busy
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_last_issue = 1'b0;
    req_ready    = '0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept  = 1'b1;
          req_ready = w_grant;
          // A zero-length burst is accepted but never leaves IDLE
          if (w_len_sel != '0) w_state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        busy         = 1'b1;
        w_issue      = 1'b1;
        w_last_issue = (r_cnt == r_len - LENW'(1));
        if (w_last_issue) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: latch the winner, then step address and offset each clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_tag      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
      r_tag <= w_win;
      r_len <= w_len_sel;
      r_cnt <= '0;
      // rom_addr only moves when reads will actually be issued
      if (w_len_sel != '0) r_rom_addr <= w_base_sel;
    end else if (w_issue && !w_last_issue) begin
      r_cnt      <= r_cnt + LENW'(1);
      r_rom_addr <= w_addr_inc;
    end
  end

  // Response stage: capture what was issued so it lines up with rom_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_vld  <= 1'b0;
      r_p_tag  <= '0;
      r_p_addr <= '0;
      r_p_idx  <= '0;
      r_p_last <= 1'b0;
    end else begin
      r_p_vld <= w_issue;
      if (w_issue) begin
        r_p_tag  <= r_tag;
        r_p_addr <= r_rom_addr;
        r_p_idx  <= r_cnt;
        r_p_last <= w_last_issue;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_valid
    assign rsp_valid[gi] = r_p_vld && (r_p_tag == IDW'(gi));
  end

  assign rom_addr = r_rom_addr;
  assign rsp_data = r_p_vld ? rom_data : '0;
  assign rsp_addr = r_p_addr;
  assign rsp_idx  = r_p_idx;
  assign rsp_last = r_p_vld && r_p_last;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Bench for rom_burst_arbiter: table of round-robin picks, directed burst
// sequences and randomized traffic, checked against a transaction model.
module tb_rom_burst_arbiter;
  import rom_burst_arbiter_pkg::*;

  localparam int N = 4, W = 8, D = 256, LW = 6, AW = 8, RING = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_base;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   rom_addr;
  logic [W-1:0]    rom_data;
  logic [N-1:0]    rsp_valid;
  logic [W-1:0]    rsp_data;
  logic [AW-1:0]   rsp_addr;
  logic [LW-1:0]   rsp_idx;
  logic            rsp_last;
  logic            busy;
  logic [W-1:0]    mem [D];

  always #5 clk = ~clk;

  // Synchronous ROM beside the arbiter
  always @(posedge clk) rom_data <= mem[rom_addr];

  rom_burst_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D), .LENW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_base(req_base),
    .req_len(req_len), .req_ready(req_ready), .rom_addr(rom_addr),
    .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_idx(rsp_idx), .rsp_last(rsp_last), .busy(busy)
  );

  typedef struct { bit v; int tag; int addr; int idx; bit last; } rsp_t;
  typedef struct { logic [N-1:0] mask; logic [N-1:0] ready; } vec_t;

  // Requester side
  logic [N-1:0]  p_valid = '0;
  logic [AW-1:0] p_base [N];
  logic [LW-1:0] p_len  [N];
  bit auto_req = 0;
  bit f_armed = 0;
  int f_trig, f_req;
  logic [AW-1:0] f_base;
  logic [LW-1:0] f_len;

  // Reference model: expected activity per cycle, indexed by cycle number
  int   cyc = 0, m_ptr = 0, m_free = 0, g_now = -1;
  bit   exp_busy [RING];
  int   exp_ra   [RING];
  rsp_t exp_rsp  [RING];
  bit   zchk = 0;
  int   grant_log[$];
  int   gcyc[$];
  int   rsp_cnt [N];
  int   last_cnt = 0;
  int   tests = 0, fails = 0;
  vec_t vt [12];
  int   rr_exp [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int j = 0; j < N; j++) begin
      req_valid[j] = p_valid[j];
      req_base[j*AW +: AW] = p_base[j];
      req_len[j*LW +: LW]  = p_len[j];
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_free = cyc + 1;
    for (int s = 0; s < RING; s++) begin
      exp_busy[s] = 0;
      exp_rsp[s].v = 0;
    end
  endtask

  task automatic check_cycle();
    int s, w, L, k, j;
    logic [N-1:0] er, ev;
    s = cyc % RING;
    if (zchk) begin
      zchk = 0;
      chk("rst_rsp_valid", rsp_valid, 0); chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0); chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rsp_addr", rsp_addr, 0);   chk("rst_rsp_idx", rsp_idx, 0);
      chk("rst_rsp_data", rsp_data, 0);   chk("rst_rsp_last", rsp_last, 0);
    end
    w = -1;
    if (cyc >= m_free)
      for (k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && p_valid[j]) w = j;
      end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("busy", busy, exp_busy[s]);
    if (exp_busy[s]) chk("rom_addr", rom_addr, exp_ra[s]);
    ev = '0;
    if (exp_rsp[s].v) ev[exp_rsp[s].tag] = 1'b1;
    chk("rsp_valid", rsp_valid, ev);
    if (exp_rsp[s].v) begin
      chk("rsp_data", rsp_data, mem[exp_rsp[s].addr]);
      chk("rsp_addr", rsp_addr, exp_rsp[s].addr);
      chk("rsp_idx", rsp_idx, exp_rsp[s].idx);
      chk("rsp_last", rsp_last, exp_rsp[s].last);
    end else chk("rsp_last_idle", rsp_last, 0);
    for (int q = 0; q < N; q++) if (rsp_valid[q] === 1'b1) rsp_cnt[q]++;
    if (rsp_valid != '0 && rsp_last === 1'b1) last_cnt++;
    exp_busy[s] = 0;
    exp_rsp[s].v = 0;
    if (w >= 0) begin
      g_now = w;
      grant_log.push_back(w);
      gcyc.push_back(cyc);
      L = int'(p_len[w]);
      m_ptr = (w + 1) % N;
      $display("[TB] cyc=%0d grant req%0d base=%02h len=%0d", cyc, w, p_base[w], L);
      for (int i = 0; i < L; i++) begin
        exp_busy[(cyc + 1 + i) % RING] = 1;
        exp_ra[(cyc + 1 + i) % RING]   = (int'(p_base[w]) + i) % D;
        exp_rsp[(cyc + 2 + i) % RING]  = '{v: 1, tag: w, addr: (int'(p_base[w]) + i) % D,
                                           idx: i, last: (i == L - 1)};
      end
      m_free = cyc + ((L == 0) ? 1 : L + 1);
    end
  endtask

  task automatic new_req(input int j);
    p_valid[j] = 1'b1;
    p_base[j]  = AW'($urandom_range(0, 255));
    case ($urandom_range(0, 9))
      0: p_len[j] = '0;
      1: p_len[j] = 6'd63;
      default: p_len[j] = LW'($urandom_range(1, 6));
    endcase
  endtask

  // One clock: check this cycle against the model, then let requesters react
  task automatic cycle();
    @(negedge clk);
    g_now = -1;
    if (rst_n) check_cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    cyc++;
    #1;
    if (g_now >= 0) begin
      p_valid[g_now] = 1'b0;
      if (f_armed && g_now == f_trig) begin
        p_valid[f_req] = 1'b1; p_base[f_req] = f_base; p_len[f_req] = f_len;
        f_armed = 0;
      end
    end
    if (auto_req)
      for (int j = 0; j < N; j++) if (!p_valid[j] && $urandom_range(0, 3) == 0) new_req(j);
    drive();
  endtask

  task automatic clear_logs();
    grant_log.delete(); gcyc.delete(); last_cnt = 0;
    for (int j = 0; j < N; j++) rsp_cnt[j] = 0;
  endtask

  task automatic do_reset();
    p_valid = '0; auto_req = 0; f_armed = 0;
    drive();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    zchk = 1;
    cycle();
    clear_logs();
  endtask

  task automatic wait_grants(input int n);
    int k;
    k = 0;
    while (grant_log.size() < n && k < 200) begin cycle(); k++; end
    chk("grant_wait", grant_log.size(), n);
  endtask

  task automatic drain();
    for (int k = 0; k < 1500 && (p_valid != '0 || cyc < m_free + 2); k++) cycle();
    chk("drain_done", p_valid, 0);
  endtask

  task automatic start(input int j, input logic [AW-1:0] b, input logic [LW-1:0] l);
    p_valid[j] = 1'b1; p_base[j] = b; p_len[j] = l;
  endtask

  initial begin
    vt[0]  = '{4'b1111, 4'b0001}; vt[1]  = '{4'b1111, 4'b0010};
    vt[2]  = '{4'b0001, 4'b0001}; vt[3]  = '{4'b1001, 4'b1000};
    vt[4]  = '{4'b0110, 4'b0010}; vt[5]  = '{4'b0000, 4'b0000};
    vt[6]  = '{4'b0011, 4'b0001}; vt[7]  = '{4'b1100, 4'b0100};
    vt[8]  = '{4'b1110, 4'b1000}; vt[9]  = '{4'b0100, 4'b0100};
    vt[10] = '{4'b0111, 4'b0001}; vt[11] = '{4'b1111, 4'b0010};
    rr_exp = '{0, 1, 2, 3, 0};
    for (int a = 0; a < D; a++) mem[a] = W'(a);
    for (int j = 0; j < N; j++) begin p_base[j] = '0; p_len[j] = '0; end
    drive();

    // Reset state, then round-robin pick table with zero-length bursts
    do_reset();
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < N; j++) begin
        p_valid[j] = vt[r].mask[j]; p_base[j] = AW'(j * 16); p_len[j] = '0;
      end
      drive();
      @(negedge clk);
      chk("tbl_ready", req_ready, vt[r].ready);
      chk("tbl_busy", busy, 0);
      chk("tbl_rsp_valid", rsp_valid, 0);
      @(posedge clk); #1;
      cyc++;
    end

    // Single burst: base 0x10, len 4, ROM word = address
    do_reset();
    start(REQ_DUCK, 8'h10, 6'd4); drive();
    wait_grants(1); drain();
    chk("single_words", rsp_cnt[REQ_DUCK], 4);
    chk("single_last", last_cnt, 1);

    // Round-robin with req0 re-requesting as soon as it is granted
    do_reset();
    for (int a = 0; a < D; a++) mem[a] = W'(a * 7 + 3);
    start(REQ_DUCK, 8'h00, 6'd2); start(REQ_OBST, 8'h40, 6'd2);
    start(REQ_GROUND, 8'h80, 6'd2); start(REQ_SCORE, 8'hC0, 6'd2);
    f_armed = 1; f_trig = REQ_DUCK; f_req = REQ_DUCK; f_base = 8'h20; f_len = 6'd2;
    drive();
    wait_grants(5); drain();
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], rr_exp[i]);
    for (int i = 0; i < 4 && i + 1 < gcyc.size(); i++) chk("rr_spacing", gcyc[i+1] - gcyc[i], 3);
    chk("rr_words0", rsp_cnt[0], 4);
    chk("rr_words3", rsp_cnt[3], 2);

    // Wrap-around past the top of the ROM
    do_reset();
    start(REQ_OBST, 8'hFE, 6'd4); drive();
    wait_grants(1); drain();
    chk("wrap_words", rsp_cnt[REQ_OBST], 4);

    // Zero length followed immediately by a one-word burst
    do_reset();
    start(REQ_GROUND, 8'h55, 6'd0);
    f_armed = 1; f_trig = REQ_GROUND; f_req = REQ_OBST; f_base = 8'h33; f_len = 6'd1;
    drive();
    wait_grants(2); drain();
    if (grant_log.size() >= 2) begin
      chk("zero_first", grant_log[0], REQ_GROUND);
      chk("zero_next", grant_log[1], REQ_OBST);
      chk("zero_gap", gcyc[1] - gcyc[0], 1);
    end
    chk("zero_words2", rsp_cnt[REQ_GROUND], 0);
    chk("zero_words1", rsp_cnt[REQ_OBST], 1);

    // Reset during the fourth cycle of a len=8 burst
    do_reset();
    start(REQ_DUCK, 8'h50, 6'd8); drive();
    wait_grants(1);
    cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    zchk = 1;
    cycle();
    clear_logs();
    start(REQ_DUCK, 8'h60, 6'd1); start(REQ_OBST, 8'h70, 6'd1); drive();
    wait_grants(2); drain();
    if (grant_log.size() >= 1) chk("rst_first_grant", grant_log[0], REQ_DUCK);

    // Maximum-length burst
    do_reset();
    start(REQ_SCORE, 8'h00, 6'd63); drive();
    wait_grants(1); drain();
    chk("max_words", rsp_cnt[REQ_SCORE], 63);
    chk("max_last", last_cnt, 1);

    // Randomized traffic against the model
    do_reset();
    for (int a = 0; a < D; a++) mem[a] = W'($urandom_range(0, 255));
    auto_req = 1;
    repeat (2000) cycle();
    auto_req = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
